fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 105 ++++++++++
 tb/tb_fifo_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Synchronous FIFO with registered read data, occupancy-based status flags,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_param #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   umb_almost_full,
  input  logic [ADDR_WIDTH:0]   umb_almost_empty,
  input  logic                  err_clear,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCount = (ADDR_WIDTH + 1)'(Depth);

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic wr_acc, rd_acc, ovf_evt, unf_evt;

  always_comb begin
    fifo_empty   = (count_q == '0);
    fifo_full    = (count_q == DepthCount);
    almost_full  = (count_q >= umb_almost_full);
    almost_empty = (count_q <= umb_almost_empty);

    // A push at full is only accepted when a pop frees the slot in the same cycle.
    wr_acc  = write && (!fifo_full || read);
    rd_acc  = read && !fifo_empty;
    ovf_evt = write && fifo_full && !read;
    unf_evt = read && fifo_empty;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem_q[rd_ptr_q];
      valid_d    = 1'b1;
    end

    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;

    // A new error in the same cycle as err_clear keeps the flag set.
    ovf_d = (ovf_q && !err_clear) || ovf_evt;
    unf_d = (unf_q && !err_clear) || unf_evt;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage is not reset; the write is gated so requests during reset are ignored.
  always_ff @(posedge clk) begin
    if (wr_acc && reset_L) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out      = data_out_q;
  assign valid_out     = valid_q;
  assign data_count    = count_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param at default sizing (DEPTH=4, 6-bit data).
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [5:0] data_in = '0;
  logic [2:0] umb_almost_full = 3'd3;
  logic [2:0] umb_almost_empty = 3'd1;
  logic       err_clear = 1'b0;
  logic [5:0] data_out;
  logic       valid_out;
  logic [2:0] data_count;
  logic       fifo_full, fifo_empty, almost_full, almost_empty;
  logic       overflow_err, underflow_err;

  int vectors = 0;
  int miscompares = 0;

  fifo_param dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .write            (write),
    .read             (read),
    .data_in          (data_in),
    .umb_almost_full  (umb_almost_full),
    .umb_almost_empty (umb_almost_empty),
    .err_clear        (err_clear),
    .data_out         (data_out),
    .valid_out        (valid_out),
    .data_count       (data_count),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .almost_full      (almost_full),
    .almost_empty     (almost_empty),
    .overflow_err     (overflow_err),
    .underflow_err    (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] d);
    write = 1'b1; read = 1'b0; data_in = d;
    tick();
    write = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [5:0] exp);
    read = 1'b1; write = 1'b0;
    tick();
    read = 1'b0;
    chk({tag, "_data"}, 32'(data_out), 32'(exp));
    chk({tag, "_valid"}, 32'(valid_out), 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_count", 32'(data_count), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_errs", 32'({overflow_err, underflow_err}), 32'd0);
    #5 reset_L = 1'b1;
    tick();

    // Fill to full, checking thresholds on the way
    push(6'h01); push(6'h02); push(6'h03);
    chk("fill3_count", 32'(data_count), 32'd3);
    chk("fill3_afull", 32'(almost_full), 32'd1);
    chk("fill3_full", 32'(fifo_full), 32'd0);
    chk("fill3_aempty", 32'(almost_empty), 32'd0);
    push(6'h04);
    chk("fill4_count", 32'(data_count), 32'd4);
    chk("fill4_full", 32'(fifo_full), 32'd1);

    pop_chk("drain1", 6'h01);
    pop_chk("drain2", 6'h02);
    pop_chk("drain3", 6'h03);
    chk("drain3_aempty", 32'(almost_empty), 32'd1);
    pop_chk("drain4", 6'h04);
    chk("drain_empty", 32'(fifo_empty), 32'd1);
    tick();
    chk("idle_valid", 32'(valid_out), 32'd0);
    chk("idle_hold", 32'(data_out), 32'd4);

    // Simultaneous push and pop at full
    push(6'h11); push(6'h12); push(6'h13); push(6'h14);
    write = 1'b1; read = 1'b1; data_in = 6'h2A;
    tick();
    write = 1'b0; read = 1'b0;
    chk("rw_full_data", 32'(data_out), 32'h11);
    chk("rw_full_count", 32'(data_count), 32'd4);
    pop_chk("rw_pop1", 6'h12);
    pop_chk("rw_pop2", 6'h13);
    pop_chk("rw_pop3", 6'h14);
    pop_chk("rw_pop4", 6'h2A);

    // Underflow, then clear
    read = 1'b1;
    tick();
    read = 1'b0;
    chk("unf_flag", 32'(underflow_err), 32'd1);
    chk("unf_data", 32'(data_out), 32'h2A);
    chk("unf_valid", 32'(valid_out), 32'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("unf_clear", 32'(underflow_err), 32'd0);

    // Overflow drops data; error wins over a same-cycle clear
    push(6'h01); push(6'h02); push(6'h03); push(6'h04);
    push(6'h3F);
    chk("ovf_flag", 32'(overflow_err), 32'd1);
    chk("ovf_count", 32'(data_count), 32'd4);
    err_clear = 1'b1; write = 1'b1; data_in = 6'h3E;
    tick();
    write = 1'b0;
    chk("ovf_clr_race", 32'(overflow_err), 32'd1);
    tick();
    err_clear = 1'b0;
    chk("ovf_clear", 32'(overflow_err), 32'd0);
    pop_chk("ovf_pop1", 6'h01);
    pop_chk("ovf_pop2", 6'h02);
    pop_chk("ovf_pop3", 6'h03);
    pop_chk("ovf_pop4", 6'h04);

    // Read and write at empty: only the push completes, no fall-through
    write = 1'b1; read = 1'b1; data_in = 6'h09;
    tick();
    write = 1'b0; read = 1'b0;
    chk("empty_rw_count", 32'(data_count), 32'd1);
    chk("empty_rw_valid", 32'(valid_out), 32'd0);
    chk("empty_rw_data", 32'(data_out), 32'h04);
    pop_chk("empty_rw_pop", 6'h09);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;

    // Pointer wrap over 10 push/pop pairs
    for (int i = 0; i < 10; i++) begin
      push(6'(6'h20 + i));
      chk($sformatf("wrap%0d_count", i), 32'(data_count), 32'd1);
      pop_chk($sformatf("wrap%0d", i), 6'(6'h20 + i));
    end

    // Thresholds act combinationally
    umb_almost_empty = 3'd0; umb_almost_full = 3'd0;
    #1;
    chk("thr_aempty", 32'(almost_empty), 32'd1);
    chk("thr_afull", 32'(almost_full), 32'd1);
    umb_almost_full = 3'd1;
    #1;
    chk("thr_afull_off", 32'(almost_full), 32'd0);
    umb_almost_full = 3'd3; umb_almost_empty = 3'd1;
    tick();

    // Asynchronous reset mid-transfer
    push(6'h31); push(6'h32); push(6'h33);
    pop_chk("pre_rst", 6'h31);
    #2 reset_L = 1'b0;
    #1;
    chk("arst_count", 32'(data_count), 32'd0);
    chk("arst_data", 32'(data_out), 32'd0);
    chk("arst_valid", 32'(valid_out), 32'd0);
    chk("arst_empty", 32'(fifo_empty), 32'd1);
    write = 1'b1; data_in = 6'h3C;
    tick();
    write = 1'b0;
    chk("rst_ignore", 32'(data_count), 32'd0);
    #3 reset_L = 1'b1;
    tick();
    push(6'h15);
    chk("post_rst_count", 32'(data_count), 32'd1);
    pop_chk("post_rst", 6'h15);
    chk("post_rst_empty", 32'(fifo_empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
